// File: rtl/gf163_pkg.sv
// Shared constants, reduction taps and FSM encoding for the B-163/K-163 reduction stage.
// f(x) = x^163 + x^7 + x^6 + x^3 + 1, so x^163 folds back onto taps {0,3,6,7}.
package gf163_pkg;

  localparam int M       = 163;
  localparam int PROD_W  = 2 * M - 1;  // 325
  localparam int NTAPS   = 4;
  localparam int MAX_TAP = 7;

  localparam int unsigned TAPS [NTAPS] = '{0, 3, 6, 7};

  // After the first fold the highest possible degree is (PROD_W-1-M) + MAX_TAP = 168.
  localparam int FOLD1_W = PROD_W - M + MAX_TAP;  // 169
  localparam int FOLD2_H = FOLD1_W - M;           // 6

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FOLD1 = 2'd1,
    FOLD2 = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/gf163_fold.sv
// One combinational reduction fold: res = lo ^ hi * (1 + x^3 + x^6 + x^7) over GF(2).
// Output is wide enough to hold both lo and the highest shifted copy of hi.
module gf163_fold
  import gf163_pkg::*;
#(
  parameter int HI_W  = 162,
  parameter int LO_W  = 163,
  parameter int OUT_W = (LO_W > HI_W + MAX_TAP) ? LO_W : HI_W + MAX_TAP
) (
  input  logic [HI_W-1:0]  hi,
  input  logic [LO_W-1:0]  lo,
  output logic [OUT_W-1:0] res
);

  logic [OUT_W-1:0] term [NTAPS];
  logic [OUT_W-1:0] sum;

  // One shifted copy of hi per nonzero coefficient of the reduction polynomial tail.
  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
    assign term[gi] = OUT_W'(hi) << TAPS[gi];
  end

  always_comb begin
    sum = OUT_W'(lo);
    for (int t = 0; t < NTAPS; t++) begin
      sum = sum ^ term[t];
    end
  end

  assign res = sum;

endmodule

// File: rtl/gf163_reduce.sv
// Sequential reduction of a 325-bit GF(2) product modulo x^163+x^7+x^6+x^3+1.
// Two folds, one per cycle, with valid/ready handshakes on both sides.
module gf163_reduce
  import gf163_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M-1:0]      out_res
);

  state_t             state_reg, state_next;
  logic [PROD_W-1:0]  acc_reg;
  logic [M-1:0]       res_reg;
  logic               out_valid_reg;

  logic [FOLD1_W-1:0] fold1_res;
  logic [M-1:0]       fold2_res;

  // Both folds read the accumulator continuously; the state decides which result is kept.
  gf163_fold #(
    .HI_W (PROD_W - M),
    .LO_W (M)
  ) u_fold1 (
    .hi  (acc_reg[PROD_W-1:M]),
    .lo  (acc_reg[M-1:0]),
    .res (fold1_res)
  );

  gf163_fold #(
    .HI_W (FOLD2_H),
    .LO_W (M)
  ) u_fold2 (
    .hi  (acc_reg[FOLD1_W-1:M]),
    .lo  (acc_reg[M-1:0]),
    .res (fold2_res)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = FOLD1;
      FOLD1:   state_next = FOLD2;
      FOLD2:   state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      res_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) acc_reg <= in_prod;
        end
        FOLD1: begin
          // Degree now at most 168; clear everything above it.
          acc_reg <= {{(PROD_W - FOLD1_W){1'b0}}, fold1_res};
        end
        FOLD2: begin
          res_reg       <= fold2_res;
          out_valid_reg <= 1'b1;
        end
        HOLD: begin
          if (out_ready) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign out_res   = res_reg;

endmodule

// File: tb/tb_gf163_reduce.sv
// Directed and random checks of gf163_reduce against a long-division model of mod f(x).
module tb_gf163_reduce;

  localparam int M  = 163;
  localparam int PW = 325;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_prod = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [M-1:0]  out_res;

  int checks = 0;
  int failures = 0;

  logic [M-1:0] exp_q [$];

  gf163_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res)
  );

  always #5 clk = ~clk;

  // Reference: plain bitwise long division of c(x) by f(x).
  function automatic logic [M-1:0] model_reduce(input logic [PW-1:0] c);
    logic [PW-1:0] r;
    logic [PW-1:0] f;
    r = c;
    f = '0;
    f[163] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
    for (int i = PW - 1; i >= M; i--) begin
      if (r[i]) r = r ^ (f << (i - M));
    end
    return r[M-1:0];
  endfunction

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [PW-1:0] rand_prod();
    logic [351:0] w;
    for (int i = 0; i < 11; i++) w[i*32 +: 32] = $urandom;
    return w[PW-1:0];
  endfunction

  // Scoreboard: expectation pushed on every accept, checked on every valid output cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_valid", M'(out_valid), '0);
        end else begin
          chk("mon_res", out_res, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model_reduce(in_prod));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product, wait (bounded) for acceptance; returns 1 tick after the accept edge.
  task automatic send(input logic [PW-1:0] p);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("send_timeout", M'(in_ready), M'(1));
    in_valid = 1'b1;
    in_prod  = p;
    tick();
    in_valid = 1'b0;
    in_prod  = rand_prod();  // upstream may change it after the accept edge
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) chk(name, M'(out_valid), M'(1));
  endtask

  // Send with out_ready=1, check latency (valid after accept edge + 2) and the result.
  task automatic reduce_check(input string name, input logic [PW-1:0] p, input logic [M-1:0] req);
    send(p);
    chk({name, "_lat0"}, M'(out_valid), '0);
    tick();
    chk({name, "_lat1"}, M'(out_valid), '0);
    tick();
    chk({name, "_lat2"}, M'(out_valid), M'(1));
    chk(name, out_res, req);
    tick();
  endtask

  initial begin
    logic [PW-1:0] p, p2;
    logic [M-1:0]  e, e_hold;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", M'(out_valid), '0);
    chk("rst_out_res", out_res, '0);
    chk("rst_in_ready", M'(in_ready), M'(1));

    // Pin the model with hand-computed values
    p = '0; p[163] = 1'b1;
    chk("model_x163", model_reduce(p), M'(8'hC9));
    p = '0; p[324] = 1'b1;
    e = M'(16'h1422); e[161] = 1'b1;
    chk("model_x324", model_reduce(p), e);

    // Directed vectors
    p = '0; p[163] = 1'b1;
    reduce_check("x163", p, M'(8'hC9));
    p = '0; p[324] = 1'b1;
    reduce_check("x324", p, e);
    reduce_check("passthru", PW'(20'h12345), M'(20'h12345));
    reduce_check("zero", '0, '0);
    p = '1;
    reduce_check("all_ones", p, model_reduce(p));

    // Random products
    for (int k = 0; k < 200; k++) begin
      p = rand_prod();
      reduce_check("rand", p, model_reduce(p));
    end

    // Back-to-back stream; the scoreboard checks each result
    for (int k = 0; k < 8; k++) send(rand_prod());
    wait_valid("stream_timeout");
    repeat (6) tick();

    // Backpressure
    out_ready = 1'b0;
    p  = rand_prod();
    p2 = rand_prod();
    send(p);
    wait_valid("bp_timeout");
    e_hold = model_reduce(p);
    in_valid = 1'b1;
    in_prod  = p2;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_valid", M'(out_valid), M'(1));
      chk("bp_res", out_res, e_hold);
      chk("bp_in_ready", M'(in_ready), '0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", M'(out_valid), '0);
    chk("bp_release_ready", M'(in_ready), M'(1));
    tick();  // p2 accepted on this edge
    in_valid = 1'b0;
    wait_valid("bp_next_timeout");
    chk("bp_next_res", out_res, model_reduce(p2));
    tick();

    // Reset during FOLD1
    send(rand_prod());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_fold1_valid", M'(out_valid), '0);
    chk("rst_fold1_res", out_res, '0);
    chk("rst_fold1_ready", M'(in_ready), M'(1));

    // Reset while holding a result
    out_ready = 1'b0;
    send(rand_prod());
    wait_valid("rst_hold_timeout");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rst_hold_valid", M'(out_valid), '0);
    chk("rst_hold_res", out_res, '0);
    chk("rst_hold_ready", M'(in_ready), M'(1));

    p = rand_prod();
    reduce_check("post_rst", p, model_reduce(p));

    repeat (3) tick();
    chk("scoreboard_drained", M'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
